// File: rtl/uart_pkg.sv
// Shared UART constants and transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned NB_DATA_DEF    = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned SB_TICK_DEF    = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request found searching upward from i_last+1, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned NB_ID = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [NB_ID-1:0] i_last,
  output logic             o_valid_c,
  output logic [N_REQ-1:0] o_grant_c,
  output logic [NB_ID-1:0] o_grant_id_c
);

  logic [NB_ID-1:0] idx;

  // Walk the N_REQ candidates in priority order; the first asserted one wins.
  always_comb begin
    o_valid_c    = 1'b0;
    o_grant_c    = '0;
    o_grant_id_c = '0;
    idx          = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = NB_ID'((32'(i_last) + k) % N_REQ);
      if (!o_valid_c && i_req[idx]) begin
        o_valid_c      = 1'b1;
        o_grant_c[idx] = 1'b1;
        o_grant_id_c   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among N_REQ byte producers with round-robin arbitration.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA    = NB_DATA_DEF,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned SB_TICK    = SB_TICK_DEF,
  parameter int unsigned NB_ID      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_tick,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [NB_ID-1:0]         o_grant_id,
  output logic                     o_busy,
  output logic                     o_tx
);

  localparam int unsigned TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TW       = $clog2(TICK_MAX);
  localparam int unsigned BW       = $clog2(NB_DATA + 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [NB_ID-1:0]   gid_q, gid_d;
  logic [NB_ID-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic               tx_q, tx_d;

  logic               arb_valid;
  logic [N_REQ-1:0]   arb_gnt;
  logic [NB_ID-1:0]   arb_id;
  logic [NB_DATA-1:0] sel_byte;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .NB_ID (NB_ID)
  ) u_arb (
    .i_req        (i_req),
    .i_last       (last_q),
    .o_valid_c    (arb_valid),
    .o_grant_c    (arb_gnt),
    .o_grant_id_c (arb_id)
  );

  // One-hot mux of the granted requester's byte.
  always_comb begin
    sel_byte = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) sel_byte = sel_byte | i_data[k*NB_DATA +: NB_DATA];
    end
  end

  // Next-state, counters and registered-output precompute.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ack_d   = '0;
    gid_d   = gid_q;
    last_d  = last_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (arb_valid) begin
          state_d = ST_START;
          shift_d = sel_byte;
          ack_d   = arb_gnt;
          gid_d   = arb_id;
          last_d  = arb_id;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == TW'(OVERSAMPLE - 1)) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BW'(NB_DATA - 1)) begin
              bit_d   = '0;
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so o_tx falls with the grant.
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      last_q  <= NB_ID'(N_REQ - 1);
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_grant_id = gid_q;
  assign o_busy     = busy_q;
  assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-offset reference model plus directed scenarios.
module tb_uart_tx_scheduler;

  localparam int NB_DATA     = 8;
  localparam int N_REQ       = 4;
  localparam int OVERSAMPLE  = 16;
  localparam int SB_TICK     = 16;
  localparam int NB_ID       = 2;
  localparam int DATA_END    = OVERSAMPLE * (1 + NB_DATA);
  localparam int FRAME_TICKS = DATA_END + SB_TICK;

  logic                     clk = 1'b0;
  logic                     i_rst;
  logic                     i_tick;
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_DATA-1:0] i_data;
  logic [N_REQ-1:0]         o_ack;
  logic [NB_ID-1:0]         o_grant_id;
  logic                     o_busy;
  logic                     o_tx;

  uart_tx_scheduler #(
    .NB_DATA    (NB_DATA),
    .N_REQ      (N_REQ),
    .OVERSAMPLE (OVERSAMPLE),
    .SB_TICK    (SB_TICK),
    .NB_ID      (NB_ID)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_tx       (o_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is just a tick offset from its grant.
  bit               m_busy;
  int               m_e;
  logic [7:0]       m_byte;
  int               m_gid;
  int               m_last;
  logic [N_REQ-1:0] m_ack;

  int  tick_mode;
  int  cyc;
  int  rem [N_REQ];
  int  busy_cnt;
  logic prev_tx;
  int  ack_log[$];
  int  ack_cyc[$];
  int  tx_edges[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_e    = 0;
    m_byte = '0;
    m_gid  = 0;
    m_last = N_REQ - 1;
    m_ack  = '0;
  endtask

  task automatic model_step();
    m_ack = '0;
    if (!m_busy) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (i_req[c]) begin
          m_busy   = 1'b1;
          m_e      = 0;
          m_gid    = c;
          m_last   = c;
          m_ack[c] = 1'b1;
          m_byte   = i_data[c*NB_DATA +: NB_DATA];
          break;
        end
      end
    end else if (i_tick) begin
      m_e++;
      if (m_e == FRAME_TICKS) m_busy = 1'b0;
    end
  endtask

  function automatic logic exp_tx();
    if (!m_busy)           return 1'b1;
    if (m_e < OVERSAMPLE)  return 1'b0;
    if (m_e < DATA_END)    return m_byte[(m_e - OVERSAMPLE) / OVERSAMPLE];
    return 1'b1;
  endfunction

  // One clock: drive tick, step model at the edge, compare #1 later.
  task automatic cycle();
    case (tick_mode)
      0:       i_tick = 1'b1;
      1:       i_tick = (cyc % 5 == 0);
      default: i_tick = ($urandom_range(0, 2) == 0);
    endcase
    @(posedge clk);
    cyc++;
    if (i_rst) model_reset();
    else       model_step();
    #1;
    check_eq("tx",   32'(o_tx),       32'(exp_tx()));
    check_eq("busy", 32'(o_busy),     32'(m_busy));
    check_eq("ack",  32'(o_ack),      32'(m_ack));
    check_eq("gid",  32'(o_grant_id), 32'(m_gid));
    if (o_ack != '0) begin
      for (int k = 0; k < N_REQ; k++) if (o_ack[k]) ack_log.push_back(k);
      ack_cyc.push_back(cyc);
    end
    if (o_busy) busy_cnt++;
    if (o_tx !== prev_tx) tx_edges.push_back(cyc);
    prev_tx = o_tx;
  endtask

  // Requesters react to the model's ack: reload the next byte or drop the request.
  task automatic serve_acks();
    for (int k = 0; k < N_REQ; k++) begin
      if (m_ack[k]) begin
        if (rem[k] > 0) begin
          rem[k]--;
          i_data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
        end else begin
          i_req[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    ack_log.delete();
    ack_cyc.delete();
    tx_edges.delete();
    busy_cnt = 0;
    prev_tx  = o_tx;
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_req  = '0;
    i_data = '0;
    for (int k = 0; k < N_REQ; k++) rem[k] = 0;
    model_reset();
    repeat (3) cycle();
    i_rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_busy || i_req != '0) && n < budget) begin
      cycle();
      serve_acks();
      n++;
    end
    if (n >= budget) check_eq("drain_timeout", 32'({o_busy, i_req}), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    cyc       = 0;
    tick_mode = 0;
    i_tick    = 1'b0;
    i_rst     = 1'b1;
    prev_tx   = 1'b1;

    // Single byte 0x55 with a tick every clock.
    do_reset();
    i_data[7:0] = 8'h55;
    i_req       = 4'b0001;
    drain(400);
    check_eq("single_acks", 32'(ack_log.size()), 32'(1));
    if (ack_log.size() > 0) check_eq("single_id", 32'(ack_log[0]), 32'(0));
    check_eq("single_busy_cycles", 32'(busy_cnt), 32'(FRAME_TICKS));

    // All four requesting at once: served 0,1,2,3, one IDLE clock between frames.
    do_reset();
    i_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    i_req  = 4'b1111;
    drain(1000);
    check_eq("simul_acks", 32'(ack_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check_eq("simul_order", 32'(ack_log[i]), 32'(i));
      if (i > 0) check_eq("simul_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(FRAME_TICKS + 1));
    end

    // Fairness between two continuously requesting producers.
    do_reset();
    i_data = {8'h00, 8'h3C, 8'h00, 8'hC3};
    rem[0] = 1;
    rem[2] = 1;
    i_req  = 4'b0101;
    drain(1000);
    check_eq("fair_acks", 32'(ack_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check_eq("fair_order", 32'(ack_log[i]), 32'((i % 2 == 0) ? 0 : 2));

    // Tick every 5th clock: each data bit spans 80 clocks.
    do_reset();
    tick_mode   = 1;
    i_data[7:0] = 8'h55;
    i_req       = 4'b0001;
    drain(2000);
    check_eq("pace_edges", 32'(tx_edges.size()), 32'(10));
    for (int i = 1; i < 9 && i + 1 < tx_edges.size(); i++)
      check_eq("pace_bit_len", 32'(tx_edges[i+1] - tx_edges[i]), 32'(5 * OVERSAMPLE));
    tick_mode = 0;

    // Asynchronous reset during data bit 3 of 0x0F.
    do_reset();
    i_data[7:0] = 8'h0F;
    i_req       = 4'b0001;
    begin
      int n;
      n = 0;
      while (!(m_busy && m_e >= OVERSAMPLE * 4 + 5) && n < 300) begin
        cycle();
        serve_acks();
        n++;
      end
      check_eq("rst_reached_bit3", 32'(o_busy), 32'(1));
    end
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("rst_async_tx",   32'(o_tx),   32'(1));
    check_eq("rst_async_busy", 32'(o_busy), 32'(0));
    model_reset();
    i_req  = 4'b0011;
    i_data = {8'h00, 8'h00, 8'h5A, 8'hA5};
    repeat (2) cycle();
    i_rst = 1'b0;
    clear_logs();
    drain(1000);
    check_eq("rst_acks", 32'(ack_log.size()), 32'(2));
    if (ack_log.size() >= 2) begin
      check_eq("rst_first",  32'(ack_log[0]), 32'(0));
      check_eq("rst_second", 32'(ack_log[1]), 32'(1));
    end

    // Requester 2 pulses mid-frame and is gone by IDLE: never served.
    do_reset();
    i_data[7:0] = 8'h96;
    i_req       = 4'b0001;
    repeat (30) begin
      cycle();
      serve_acks();
    end
    i_data[23:16] = 8'h77;
    i_req[2]      = 1'b1;
    cycle();
    i_req[2] = 1'b0;
    drain(400);
    repeat (20) cycle();
    check_eq("wd_acks", 32'(ack_log.size()), 32'(1));
    if (ack_log.size() > 0) check_eq("wd_id", 32'(ack_log[0]), 32'(0));
    check_eq("wd_line_idle", 32'(o_tx), 32'(1));

    // Random traffic, random tick spacing, occasional withdrawals.
    do_reset();
    tick_mode = 2;
    repeat (6000) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!i_req[k] && $urandom_range(0, 39) == 0) begin
          i_req[k] = 1'b1;
          rem[k]   = $urandom_range(0, 2);
          i_data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
        end else if (i_req[k] && $urandom_range(0, 199) == 0) begin
          i_req[k] = 1'b0;
        end
      end
      cycle();
      serve_acks();
    end
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART serial transmit line among `N_REQ` byte producers. It serialises each granted byte as an 8N1-style frame paced by the oversampling tick from the baud-rate generator. The block sits between the system's byte sources and the `o_tx` pin, and consumes the generator's `o_tick` as `i_tick`. It owns arbitration, frame sequencing and bit timing; it never generates ticks itself.

## Interface
- `NB_DATA`, 8, data bits per frame
- `N_REQ`, 4, number of requesters (2..8)
- `OVERSAMPLE`, 16, ticks per start/data bit
- `SB_TICK`, 16, ticks in stop period (16 = 1 stop bit, 32 = 2)
- `NB_ID`, $clog2(N_REQ), grant index width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_tick`  in  1  one-cycle oversampling tick from baud-rate generator
- `i_req`  in  N_REQ  per-requester level request
- `i_data`  in  N_REQ*NB_DATA  requester k byte at bits [k*NB_DATA +: NB_DATA]
- `o_ack`  out  N_REQ  one-hot, one-cycle pulse when requester's byte is latched
- `o_grant_id`  out  NB_ID  index of requester owning current frame
- `o_busy`  out  1  high in any state except IDLE
- `o_tx`  out  1  serial line, idle high

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `o_tx`=1.
  - If any `i_req` is high, pick the first set bit searching from `last_grant+1`, wrapping modulo `N_REQ`.
  - Latch that requester's byte into the shift register.
  - Pulse its `o_ack`, load `o_grant_id` and `last_grant`, then go to START.
- START: `o_tx`=0. Advance to DATA after `OVERSAMPLE` ticks.
- DATA:
  - `o_tx` = shift_reg[0], LSB first.
  - Every `OVERSAMPLE` ticks, shift right and increment the bit counter.
  - After `NB_DATA` bits, go to STOP.
- STOP: `o_tx`=1. After `SB_TICK` ticks, return to IDLE.
- Tick counter:
  - Cleared on every state entry and at each bit boundary.
  - On `i_tick`: if count == limit-1, advance/shift and clear; otherwise increment.
  - Clock cycles without `i_tick` never change the counter.
- Requests:
  - `i_req` is level-sensitive. The requester holds `i_req` and `i_data` stable until `o_ack`.
  - Deasserting `i_req` before `o_ack` withdraws the request; no frame is sent.
  - A requester keeping `i_req` high after `o_ack` queues its next byte, served per round-robin after the current frame.
  - `i_req` is ignored outside IDLE.
- Widths: tick counter is $clog2(max(OVERSAMPLE,SB_TICK)) bits; bit counter is $clog2(NB_DATA+1) bits.

## Timing
- Reset values: state IDLE, `o_tx`=1, `o_busy`=0, `o_ack`=0, `o_grant_id`=0, `last_grant`=N_REQ-1 (requester 0 has first priority), counters 0.
- Reset is asynchronous: `o_tx` returns to 1 immediately, including mid-frame. The partial frame is discarded and not retried.
- Grant latency:
  - `i_req` sampled high in IDLE at edge n → `o_ack` high and state START during cycle n+1.
  - `o_tx` falls at edge n, i.e. registered together with the grant.
- Back-to-back frames: with a request pending on STOP exit, the next START begins one clock after IDLE is entered. The line is never low between frames.
- Frame length: exactly `OVERSAMPLE*(1+NB_DATA)+SB_TICK` ticks, plus one IDLE clock.
- An `i_tick` in the cycle a state is entered is counted.
- `o_ack` is never asserted for more than one cycle and never for more than one requester.
- `o_grant_id` is stable from grant until the next grant.

## Structure
- Shared package `uart_pkg`: FSM state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), and the default `NB_DATA`/`OVERSAMPLE`/`SB_TICK` constants shared with the UART receiver.
- Sub-module `rr_arbiter` (parameter `N_REQ`):
  - Combinational masked-priority pick from `i_req` and `last_grant`.
  - Outputs a one-hot grant and `NB_ID` index.
  - Reusable for a future RX-buffer drain scheduler.
- Top-level integration instantiates the baud-rate generator beside this block, with its `o_tick` wired to `i_tick`.

## Test plan
- Single byte: reset, `i_tick` every cycle, req0=1 with 0x55.
  - `o_ack`=4'b0001 for one cycle.
  - `o_tx`: 16 low, then bits 1,0,1,0,1,0,1,0 (16 cycles each), then 16 high.
  - `o_busy` high for 160 cycles.
- Simultaneous requests: all four `i_req` high after reset with bytes 0xA0..0xA3.
  - Acks and decoded frames in order 0,1,2,3.
  - Each ack occurs in the clock after the previous STOP completes.
- Fairness: req0 and req2 held high continuously.
  - Grants alternate 0,2,0,2.
  - Requesters 1 and 3 are never acked.
- Tick pacing: `i_tick` every 5th cycle.
  - Each bit lasts exactly 80 clocks.
  - State is frozen across non-tick cycles.
- Reset mid-DATA: assert `i_rst` during bit 3 of 0x0F.
  - `o_tx`=1 and `o_busy`=0 in the same cycle.
  - After release with req1 and req0 high, requester 0 is granted first.
- Withdrawal: req2 pulses high for one cycle while a frame is in progress and is low at IDLE.
  - No ack to requester 2.
  - Line stays high after the current frame.
